// File: rtl/dmem_pkg.sv
// Shared definitions for the wait-state data-memory responder:
// FSM state encoding, wait counter width and data word width.
package dmem_pkg;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam int CNT_W  = 4;
  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE = IDLE,
    ST_WAIT = WAIT,
    ST_DONE = DONE
  } state_t;

endpackage

// File: rtl/dmem_wait_responder_if.sv
// MEM-stage load/store bus: the pipeline side is the master and
// the wait-state memory responder is the slave.
interface dmem_wait_responder_if #(
  parameter int AW = 5
) ();

  logic          req;
  logic          we;
  logic [AW-1:0] addr;
  logic [31:0]   wdata;
  logic          busy;
  logic          ack;
  logic [31:0]   rdata;

  modport master (
    output req, we, addr, wdata,
    input  busy, ack, rdata
  );

  modport slave (
    input  req, we, addr, wdata,
    output busy, ack, rdata
  );

endinterface

// File: rtl/dmem_array.sv
// Word-addressed register array: synchronous write, asynchronous read,
// every word cleared asynchronously while clr_i is high.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int AW = 5
) (
  input  logic              clk_i,
  input  logic              clr_i,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [AW-1:0]     raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [2**AW];

  always_ff @(posedge clk_i or posedge clr_i) begin
    if (clr_i) begin
      for (int i = 0; i < 2**AW; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/dmem_wait_responder.sv
// Memory-side end of the MEM-stage bus: accepts one access, holds the
// pipeline stalled for LATENCY wait cycles, then commits and pulses ack.
module dmem_wait_responder
  import dmem_pkg::*;
#(
  parameter int AW      = 5,
  parameter int LATENCY = 2
) (
  input  logic                  Clock,
  input  logic                  Resetn,
  dmem_wait_responder_if.slave  bus
);

  state_t            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              ack_q;
  logic [DATA_W-1:0] rdata_q;

  logic              we_q;
  logic [AW-1:0]     addr_q;
  logic [DATA_W-1:0] wdata_q;

  logic              accept;
  logic              commit;
  logic [DATA_W-1:0] mem_rd;

  assign accept = (state_q == ST_IDLE) && bus.req;
  assign commit = (state_q == ST_WAIT) && (cnt_q == '0);

  dmem_array #(
    .AW (AW)
  ) u_array (
    .clk_i   (Clock),
    .clr_i   (Resetn),
    .we_i    (commit && we_q),
    .waddr_i (addr_q),
    .wdata_i (wdata_q),
    .raddr_i (addr_q),
    .rdata_o (mem_rd)
  );

  // Capture stage: request fields are frozen here and used only in WAIT.
  always_ff @(posedge Clock) begin
    if (accept) begin
      we_q    <= bus.we;
      addr_q  <= bus.addr;
      wdata_q <= bus.wdata;
    end
  end

  // Control stage: FSM, wait counter, ack pulse and load data register.
  always_ff @(posedge Clock or posedge Resetn) begin
    if (Resetn) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      ack_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      ack_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (bus.req) begin
            cnt_q   <= CNT_W'(LATENCY - 1);
            state_q <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
          end else begin
            if (!we_q) begin
              rdata_q <= mem_rd;
            end
            ack_q   <= 1'b1;
            state_q <= ST_DONE;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // busy drops in DONE so the pipeline advances during the ack cycle.
  assign bus.busy  = accept || (state_q == ST_WAIT);
  assign bus.ack   = ack_q;
  assign bus.rdata = rdata_q;

endmodule

// File: tb/tb_dmem_wait_responder.sv
// Directed bench for dmem_wait_responder: a LATENCY=2 instance for the
// access tests and a LATENCY=1 instance for back-to-back requests.
module tb_dmem_wait_responder;

  localparam int LAT_A = 2;
  localparam int LAT_B = 1;

  logic clk;
  logic rst;

  int vectors;
  int miscompares;

  logic [31:0] model_mem [32];
  logic [31:0] last_rd;
  logic [31:0] sb [$];

  dmem_wait_responder_if #(.AW(5)) bus_a ();
  dmem_wait_responder_if #(.AW(5)) bus_b ();

  dmem_wait_responder #(.AW(5), .LATENCY(LAT_A)) dut_a (
    .Clock  (clk),
    .Resetn (rst),
    .bus    (bus_a)
  );

  dmem_wait_responder #(.AW(5), .LATENCY(LAT_B)) dut_b (
    .Clock  (clk),
    .Resetn (rst),
    .bus    (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_model();
    for (int i = 0; i < 32; i++) model_mem[i] = 32'h0;
    last_rd = 32'h0;
    sb.delete();
  endtask

  task automatic idle_a(input int n, input string tag);
    bus_a.req = 1'b0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      chk1({tag, "_busy"}, bus_a.busy, 1'b0);
      chk1({tag, "_ack"}, bus_a.ack, 1'b0);
      chk({tag, "_rdata"}, bus_a.rdata, last_rd);
      next_cycle();
    end
  endtask

  // One access on instance A; starts right after a posedge, ends right after
  // the DONE->IDLE edge. With toggle set, request fields churn during WAIT.
  task automatic access_a(input logic w, input logic [4:0] a, input logic [31:0] d,
                          input bit toggle, input string tag);
    logic [31:0] exp;
    logic [31:0] got;
    bit seen;
    seen = 1'b0;
    exp = w ? last_rd : model_mem[a];
    sb.push_back(exp);
    bus_a.req   = 1'b1;
    bus_a.we    = w;
    bus_a.addr  = a;
    bus_a.wdata = d;
    for (int k = 0; k <= LAT_A + 1; k++) begin
      @(negedge clk);
      if (k == LAT_A + 1) begin
        chk1({tag, "_ack"}, bus_a.ack, 1'b1);
        chk1({tag, "_busy_done"}, bus_a.busy, 1'b0);
        got = bus_a.rdata;
        chk({tag, "_rdata"}, got, sb.pop_front());
        seen = 1'b1;
      end else begin
        chk1({tag, "_busy"}, bus_a.busy, 1'b1);
        chk1({tag, "_noack"}, bus_a.ack, 1'b0);
      end
      next_cycle();
      bus_a.req = toggle && (k < LAT_A);
      if (toggle) begin
        bus_a.we    = 1'($urandom);
        bus_a.addr  = 5'($urandom);
        bus_a.wdata = $urandom;
      end
    end
    if (!seen) chk1({tag, "_timeout"}, 1'b0, 1'b1);
    if (w) model_mem[a] = d;
    else   last_rd = exp;
    bus_a.req = 1'b0;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    clear_model();
    bus_a.req = 1'b0; bus_a.we = 1'b0; bus_a.addr = '0; bus_a.wdata = '0;
    bus_b.req = 1'b0; bus_b.we = 1'b0; bus_b.addr = '0; bus_b.wdata = '0;

    // Reset: busy follows req combinationally, ack and rdata are 0.
    rst = 1'b1;
    #12;
    bus_a.req = 1'b1;
    #1;
    chk1("rst_busy_req1", bus_a.busy, 1'b1);
    chk1("rst_ack", bus_a.ack, 1'b0);
    chk("rst_rdata", bus_a.rdata, 32'h0);
    bus_a.req = 1'b0;
    #1;
    chk1("rst_busy_req0", bus_a.busy, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    next_cycle();
    idle_a(5, "idle");

    // Store then load back.
    access_a(1'b1, 5'd3, 32'hDEADBEEF, 1'b0, "st3");
    access_a(1'b0, 5'd3, 32'h0, 1'b0, "ld3");

    // Fields toggled during WAIT must not redirect or turn load into store.
    access_a(1'b1, 5'd5, 32'h11111111, 1'b0, "st5");
    access_a(1'b0, 5'd3, 32'h0, 1'b1, "ld3_tog");
    for (int i = 0; i < 32; i++) begin
      if (i != 3 && i != 5) model_mem[i] = 32'h0;
    end
    access_a(1'b0, 5'd5, 32'h0, 1'b0, "ld5");
    access_a(1'b0, 5'd9, 32'h0, 1'b0, "ld9");
    idle_a(1, "post_tog");

    // LATENCY=1 with req held high: ack every third cycle.
    bus_b.req = 1'b1;
    bus_b.we  = 1'b0;
    bus_b.addr = 5'd0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      chk1("cont_ack", bus_b.ack, (k % 3) == 2);
      chk1("cont_busy", bus_b.busy, (k % 3) != 2);
      chk("cont_rdata", bus_b.rdata, 32'h0);
      next_cycle();
    end
    bus_b.req = 1'b0;
    next_cycle();

    // Reset pulsed mid-WAIT of a store: no ack, store discarded.
    bus_a.req = 1'b1; bus_a.we = 1'b1; bus_a.addr = 5'd7; bus_a.wdata = 32'hA5A5A5A5;
    next_cycle();
    bus_a.req = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk1("midrst_ack", bus_a.ack, 1'b0);
    chk1("midrst_busy", bus_a.busy, 1'b0);
    chk("midrst_rdata", bus_a.rdata, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    clear_model();
    next_cycle();
    idle_a(4, "after_rst");
    access_a(1'b0, 5'd7, 32'h0, 1'b0, "ld7");

    // Top and bottom words are independent.
    access_a(1'b1, 5'd31, 32'hCAFEF00D, 1'b0, "st31");
    access_a(1'b0, 5'd0, 32'h0, 1'b0, "ld0");
    access_a(1'b0, 5'd31, 32'h0, 1'b0, "ld31");
    idle_a(2, "tail");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/dmem_wait_responder.md
# dmem_wait_responder

Data-memory responder for the 5-stage pipelined CPU: the memory-side end of the MEM-stage load/store interface. It accepts one request at a time from the MEM stage and completes it after a programmable number of wait cycles. While a transaction is outstanding it drives `busy`, which the pipeline ORs into its global stall. It replaces the zero-wait `MEM_STAGE` memory when wait-state memories are exercised.

## Interface
Parameters:
- `AW`, 5, word-address width; memory holds `2**AW` 32-bit words.
- `LATENCY`, 2, wait cycles per access; legal range 1..15.

Ports:
- `Clock`  in  1  rising-edge clock.
- `Resetn`  in  1  reset; asynchronous, active-high (asserted = 1).
- `req`  in  1  MEM stage has a load or store this cycle.
- `we`  in  1  1 = store, 0 = load; qualified by `req`.
- `addr`  in  AW  word address (MEM-stage ALU result low bits).
- `wdata`  in  32  store data.
- `busy`  out  1  combinational stall request to the pipeline.
- `ack`  out  1  one-cycle completion pulse.
- `rdata`  out  32  load data; registered.

## Operation
State machine:
- IDLE
  - `req`=1: capture `we`, `addr`, `wdata`; load `cnt` = `LATENCY`-1; go to WAIT.
  - `req`=0: stay in IDLE.
- WAIT
  - `cnt`≠0: decrement `cnt`; stay in WAIT.
  - `cnt`=0: commit the transaction; go to DONE.
- DONE: `ack`=1 for this cycle; always return to IDLE. `req` is ignored in DONE.

Commit:
- Store writes captured `wdata` to `mem[addr]`.
- Load copies `mem[addr]` into `rdata`.
- Both happen on the WAIT→DONE clock edge.
- `rdata` holds its value until the next load commits; stores leave it unchanged.

Outputs:
- `busy` = (state==IDLE & `req`) | (state==WAIT). It is 0 in DONE so the pipeline advances on the `ack` cycle.
- `ack` is registered, decoded from state DONE.

Boundary conditions:
- Captured fields are used exclusively during WAIT. Changes on `req`, `we`, `addr`, `wdata` during WAIT are ignored, and a dropped `req` still completes with `ack`.
- A request held high through DONE is treated as a new request in the following IDLE cycle. The requester must therefore present each request only until `ack`.
- Address wraps naturally in AW bits; no out-of-range case exists.
- Reset (any time, including mid-WAIT):
  - state → IDLE, `cnt` → 0, `ack` → 0, `rdata` → 0;
  - all memory words → 0;
  - a pending store is discarded.

## Timing
- Request first sampled in cycle T (IDLE, `req`=1).
- `busy`=1 in cycles T..T+`LATENCY`.
- `ack`=1 and `busy`=0 in cycle T+`LATENCY`+1; `rdata` valid in that cycle.
- Total pipeline stall per access = `LATENCY`+1 cycles.
- Minimum spacing between accepted requests is `LATENCY`+2 cycles.
- Store data is visible to a load accepted at T+`LATENCY`+2 or later.
- `busy` has a combinational path from `req`. There is no other input-to-output combinational path.
- Outputs in reset: `ack`=0, `rdata`=0, `busy`=`req`. State is IDLE, so `busy` is 0 when `req` is low.

## Structure
- Shared package `dmem_pkg`:
  - state encoding localparams IDLE=2'd0, WAIT=2'd1, DONE=2'd2;
  - `CNT_W`=4.
- Sub-module `dmem_array`:
  - `2**AW`×32 register array;
  - synchronous write enable, asynchronous read;
  - asynchronous active-high clear.
- The top level holds the FSM, the capture registers, `cnt` and `rdata`.

## Test plan
- Reset then idle (`req`=0 for 5 cycles) → `busy`=0, `ack`=0, `rdata`=0 throughout.
- Store `addr`=3, `wdata`=32'hDEADBEEF, `LATENCY`=2, `req` at T → `busy`=1 in T..T+2, `ack`=1 at T+3. Then load `addr`=3 → `rdata`=32'hDEADBEEF in its `ack` cycle.
- Load while `addr`/`we` toggle during WAIT → the returned data is from the originally captured address, and no write occurs.
- `req` held high continuously with `LATENCY`=1 → `ack` every 3 cycles, `busy` low only in the `ack` cycles.
- `Resetn` pulsed mid-WAIT of a store to `addr`=7 → no `ack`; state is IDLE after release; a later load of `addr`=7 returns 0.
- `addr`=31 store then `addr`=0 load → independent words: `rdata`=0, no aliasing.
